// File: rtl/sw_cond.sv
// rtl/sw_cond.sv - push-button synchroniser, debouncer and press/release/auto-repeat strobe generator
module sw_cond #(
    parameter int DEB_CNT  = 500000,
    parameter int HOLD_CNT = 25000000,
    parameter int RPT_CNT  = 5000000,
    parameter int ACT_LOW  = 1,
    parameter int CNT_W    = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_long
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RPT  = 2'd2;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CNT - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CNT - 1);

    logic             raw_p;
    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] rcnt;
    logic [1:0]       state;
    logic             accept;
    logic             acc_press;
    logic             acc_release;

    // Normalise polarity so 1 always means pressed from here on.
    assign raw_p = (ACT_LOW != 0) ? ~i_sw : i_sw;

    // A change is accepted once sync2 has differed from o_level for DEB_CNT consecutive edges.
    assign accept      = (sync2 != o_level) && (dcnt == DEB_LAST);
    assign acc_press   = accept && sync2;
    assign acc_release = accept && !sync2;

    // Two-flop synchroniser for the asynchronous switch input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_p;
            sync2 <= sync1;
        end
    end

    // Stable-count debounce; press/release strobes fire on the same edge o_level moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt      <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= acc_press;
            o_release <= acc_release;
            if (sync2 == o_level) begin
                dcnt <= '0;
            end else if (accept) begin
                o_level <= sync2;
                dcnt    <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    // Auto-repeat FSM: strobe on press, after HOLD_CNT, then every RPT_CNT; release wins over a terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rcnt     <= '0;
            o_repeat <= 1'b0;
            o_long   <= 1'b0;
        end else begin
            o_repeat <= 1'b0;
            case (state)
                S_IDLE: begin
                    rcnt <= '0;
                    if (acc_press) begin
                        state    <= S_HOLD;
                        o_repeat <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (acc_release) begin
                        state  <= S_IDLE;
                        rcnt   <= '0;
                        o_long <= 1'b0;
                    end else if (rcnt == HOLD_LAST) begin
                        state    <= S_RPT;
                        rcnt     <= '0;
                        o_repeat <= 1'b1;
                        o_long   <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                S_RPT: begin
                    if (acc_release) begin
                        state  <= S_IDLE;
                        rcnt   <= '0;
                        o_long <= 1'b0;
                    end else if (rcnt == RPT_LAST) begin
                        rcnt     <= '0;
                        o_repeat <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    rcnt   <= '0;
                    o_long <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_cond.sv
// tb/tb_sw_cond.sv - randomized and directed bench for sw_cond against a windowed reference model
module tb_sw_cond;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 5;

    logic clk;
    logic rst_n;
    logic sw_a;
    logic sw_b;
    logic level_a, press_a, release_a, repeat_a, long_a;
    logic level_b, press_b, release_b, repeat_b, long_b;

    int errors;
    int checks;
    int n;
    bit hist[$];
    bit m_level;
    int m_p;
    bit e_press, e_rel, e_rep, e_long;

    sw_cond #(.DEB_CNT(DEB), .HOLD_CNT(HOLD), .RPT_CNT(RPT), .ACT_LOW(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_sw(sw_a),
        .o_level(level_a), .o_press(press_a), .o_release(release_a),
        .o_repeat(repeat_a), .o_long(long_a)
    );

    sw_cond #(.DEB_CNT(DEB), .HOLD_CNT(HOLD), .RPT_CNT(RPT), .ACT_LOW(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_sw(sw_b),
        .o_level(level_b), .o_press(press_b), .o_release(release_b),
        .o_repeat(repeat_b), .o_long(long_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic chk_all(input bit lv, input bit pr, input bit rl, input bit rp, input bit lg);
        chk("a_level",   level_a,   lv);
        chk("a_press",   press_a,   pr);
        chk("a_release", release_a, rl);
        chk("a_repeat",  repeat_a,  rp);
        chk("a_long",    long_a,    lg);
        chk("b_level",   level_b,   lv);
        chk("b_press",   press_b,   pr);
        chk("b_release", release_b, rl);
        chk("b_repeat",  repeat_b,  rp);
        chk("b_long",    long_b,    lg);
    endtask

    function automatic bit sample_at(input int k);
        if (k < 1) return 1'b0;
        return hist[k-1];
    endfunction

    // Reference: accept when the last DEB synchronised samples all oppose the current level.
    task automatic tick(input bit pressed);
        bit acc;
        int d;
        sw_a = ~pressed;
        sw_b = pressed;
        @(posedge clk);
        n++;
        hist.push_back(pressed);
        acc = 1'b1;
        for (int j = 0; j < DEB; j++)
            if (sample_at(n - 2 - j) == m_level) acc = 1'b0;
        e_press = acc && !m_level;
        e_rel   = acc && m_level;
        e_rep   = 1'b0;
        if (e_press) begin
            m_level = 1'b1;
            m_p     = n;
            e_rep   = 1'b1;
        end else if (e_rel) begin
            m_level = 1'b0;
        end else if (m_level) begin
            d = n - m_p;
            if (d >= HOLD && ((d - HOLD) % RPT) == 0) e_rep = 1'b1;
        end
        e_long = m_level && ((n - m_p) >= HOLD);
        #2;
        chk_all(m_level, e_press, e_rel, e_rep, e_long);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sw_a  = 1'b1;
        sw_b  = 1'b0;
        #1;
        chk_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        n = 0;
        hist.delete();
        m_level = 1'b0;
        m_p = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        n = 0;
        rst_n = 1'b0;
        sw_a = 1'b1;
        sw_b = 1'b0;
        #12;
        do_reset();

        // Short glitch never reaches the output.
        for (int i = 0; i < 3; i++) tick(1'b1);
        for (int i = 0; i < 12; i++) tick(1'b0);
        chk("glitch_level", level_a, 1'b0);

        // Clean press and long hold, then asynchronous reset while repeating.
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            tick(1'b1);
            if (n == 6) begin
                chk("p6_level", level_a, 1'b1);
                chk("p6_press", press_a, 1'b1);
                chk("p6_repeat", repeat_a, 1'b1);
            end
            if (n == 7) begin
                chk("p7_press", press_a, 1'b0);
                chk("p7_repeat", repeat_a, 1'b0);
            end
            if (n == 16) begin
                chk("p16_repeat", repeat_a, 1'b1);
                chk("p16_long", long_a, 1'b1);
            end
            if (n == 21) chk("p21_repeat", repeat_b, 1'b1);
        end
        chk("pre_rst_long", long_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Release accepted on the same edge as the third repeat terminal count.
        for (int i = 1; i <= 35; i++) begin
            tick(i <= 20);
            if (n == 26) begin
                chk("coinc_release", release_a, 1'b1);
                chk("coinc_repeat", repeat_a, 1'b0);
                chk("coinc_long", long_a, 1'b0);
                chk("coinc_level", level_a, 1'b0);
            end
        end

        // Random hold segments of varying length.
        do_reset();
        for (int s = 0; s < 80; s++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) tick(lvl);
            if (s == 40) do_reset();
        end
        for (int i = 0; i < 10; i++) tick(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
